// File: rtl/rs_ready_tracker.sv
// rs_ready_tracker: valid / operand-ready state for a WIDTH-slot reservation
// station. It produces the request vectors for the allocation and issue
// selectors, consumes their one-hot lane grants, performs CDB wakeup and
// registers the binary index of each issued slot.
//
// Optional feature: define RS_WAKEUP_BYPASS_EN to let an entry whose missing
// operand is being broadcast on the CDB request issue in that same cycle.
module rs_ready_tracker #(
    parameter int WIDTH = 16,
    parameter int REQS  = 3,
    parameter int TAG_W = 6,
    parameter int CDB_N = 3,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    squash,
    input  logic [REQS-1:0]         disp_valid,
    input  logic [REQS*TAG_W-1:0]   disp_tag1,
    input  logic [REQS-1:0]         disp_rdy1,
    input  logic [REQS*TAG_W-1:0]   disp_tag2,
    input  logic [REQS-1:0]         disp_rdy2,
    input  logic [WIDTH*REQS-1:0]   alloc_gnt_bus,
    input  logic [CDB_N-1:0]        cdb_valid,
    input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
    input  logic [WIDTH*REQS-1:0]   iss_gnt_bus,
    input  logic [REQS-1:0]         iss_accept,
    output logic [WIDTH-1:0]        free_vec,
    output logic [WIDTH-1:0]        ready_req,
    output logic [IDX_W:0]          free_cnt,
    output logic                    rs_full,
    output logic [REQS-1:0]         iss_valid,
    output logic [REQS*IDX_W-1:0]   iss_idx
);

    logic [WIDTH-1:0]      valid_q, valid_d;
    logic [WIDTH-1:0]      rdy1_q, rdy1_d;
    logic [WIDTH-1:0]      rdy2_q, rdy2_d;
    logic [TAG_W-1:0]      tag1_q [WIDTH];
    logic [TAG_W-1:0]      tag1_d [WIDTH];
    logic [TAG_W-1:0]      tag2_q [WIDTH];
    logic [TAG_W-1:0]      tag2_d [WIDTH];
    logic [REQS-1:0]       iss_valid_q, iss_valid_d;
    logic [REQS*IDX_W-1:0] iss_idx_q, iss_idx_d;

    // True when any valid CDB port is broadcasting this tag in the current cycle.
    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < CDB_N; j++) begin
            if (cdb_valid[j] && (cdb_tag[j*TAG_W +: TAG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Next-state: wakeup, then allocation, then issue; squash overrides all of it.
    always_comb begin
        // NOTE: every variable gets its hold/default value first, so no path
        // through the loops below can leave one unassigned and infer a latch.
        valid_d     = valid_q;
        rdy1_d      = rdy1_q;
        rdy2_d      = rdy2_q;
        tag1_d      = tag1_q;
        tag2_d      = tag2_q;
        iss_valid_d = '0;
        iss_idx_d   = '0;

        for (int s = 0; s < WIDTH; s++) begin
            if (valid_q[s]) begin
                if (cdb_hit(tag1_q[s])) rdy1_d[s] = 1'b1;
                if (cdb_hit(tag2_q[s])) rdy2_d[s] = 1'b1;
            end
        end

        // A dispatching lane with an empty grant lane simply writes nothing.
        for (int k = 0; k < REQS; k++) begin
            for (int s = 0; s < WIDTH; s++) begin
                if (disp_valid[k] && alloc_gnt_bus[k*WIDTH + s]) begin
                    valid_d[s] = 1'b1;
                    tag1_d[s]  = disp_tag1[k*TAG_W +: TAG_W];
                    tag2_d[s]  = disp_tag2[k*TAG_W +: TAG_W];
                    rdy1_d[s]  = disp_rdy1[k] | cdb_hit(disp_tag1[k*TAG_W +: TAG_W]);
                    rdy2_d[s]  = disp_rdy2[k] | cdb_hit(disp_tag2[k*TAG_W +: TAG_W]);
                end
            end
        end

        // One-hot grant lanes: OR-ing the indices of set bits is the binary encode.
        for (int k = 0; k < REQS; k++) begin
            iss_valid_d[k] = (|iss_gnt_bus[k*WIDTH +: WIDTH]) & iss_accept[k];
            for (int s = 0; s < WIDTH; s++) begin
                if (iss_gnt_bus[k*WIDTH + s] && iss_accept[k]) begin
                    valid_d[s]                    = 1'b0;
                    iss_idx_d[k*IDX_W +: IDX_W]   = iss_idx_d[k*IDX_W +: IDX_W] | IDX_W'(s);
                end
            end
        end

        if (squash) begin
            valid_d     = '0;
            iss_valid_d = '0;
        end
    end

    // Control state register; reset wins over squash.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of its neighbours, independent of statement order.
        if (reset) begin
            valid_q     <= '0;
            rdy1_q      <= '0;
            rdy2_q      <= '0;
            iss_valid_q <= '0;
            iss_idx_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            rdy1_q      <= rdy1_d;
            rdy2_q      <= rdy2_d;
            iss_valid_q <= iss_valid_d;
            iss_idx_q   <= iss_idx_d;
        end
    end

    // Tag storage.
    always_ff @(posedge clock) begin
        // NOTE: the tag array has no reset; an entry's tags are only looked at
        // while its valid bit is set, and allocation always rewrites them.
        tag1_q <= tag1_d;
        tag2_q <= tag2_d;
    end

    // Issue request vector, optionally including same-cycle CDB wakeup.
    always_comb begin
        ready_req = '0;
        for (int s = 0; s < WIDTH; s++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            ready_req[s] = valid_q[s] & (rdy1_q[s] | cdb_hit(tag1_q[s]))
                                      & (rdy2_q[s] | cdb_hit(tag2_q[s]));
`else
            ready_req[s] = valid_q[s] & rdy1_q[s] & rdy2_q[s];
`endif
        end
    end

    // Free-slot count for the dispatch stall decision.
    always_comb begin
        free_cnt = '0;
        for (int s = 0; s < WIDTH; s++) begin
            free_cnt = free_cnt + (IDX_W+1)'(~valid_q[s]);
        end
    end

    assign free_vec  = ~valid_q;
    assign rs_full   = (free_cnt < (IDX_W+1)'(REQS));
    assign iss_valid = iss_valid_q;
    assign iss_idx   = iss_idx_q;

endmodule

// File: tb/tb_rs_ready_tracker.sv
// Self-checking bench for rs_ready_tracker: directed scenarios followed by
// randomized traffic, compared every cycle against an entry-level model.
module tb_rs_ready_tracker;

    localparam int WIDTH = 16;
    localparam int REQS  = 3;
    localparam int TAG_W = 6;
    localparam int CDB_N = 3;
    localparam int IDX_W = 4;

    logic                    clock;
    logic                    reset;
    logic                    squash;
    logic [REQS-1:0]         disp_valid;
    logic [REQS*TAG_W-1:0]   disp_tag1;
    logic [REQS-1:0]         disp_rdy1;
    logic [REQS*TAG_W-1:0]   disp_tag2;
    logic [REQS-1:0]         disp_rdy2;
    logic [WIDTH*REQS-1:0]   alloc_gnt_bus;
    logic [CDB_N-1:0]        cdb_valid;
    logic [CDB_N*TAG_W-1:0]  cdb_tag;
    logic [WIDTH*REQS-1:0]   iss_gnt_bus;
    logic [REQS-1:0]         iss_accept;
    logic [WIDTH-1:0]        free_vec;
    logic [WIDTH-1:0]        ready_req;
    logic [IDX_W:0]          free_cnt;
    logic                    rs_full;
    logic [REQS-1:0]         iss_valid;
    logic [REQS*IDX_W-1:0]   iss_idx;

    rs_ready_tracker dut (
        .clock         (clock),
        .reset         (reset),
        .squash        (squash),
        .disp_valid    (disp_valid),
        .disp_tag1     (disp_tag1),
        .disp_rdy1     (disp_rdy1),
        .disp_tag2     (disp_tag2),
        .disp_rdy2     (disp_rdy2),
        .alloc_gnt_bus (alloc_gnt_bus),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .iss_gnt_bus   (iss_gnt_bus),
        .iss_accept    (iss_accept),
        .free_vec      (free_vec),
        .ready_req     (ready_req),
        .free_cnt      (free_cnt),
        .rs_full       (rs_full),
        .iss_valid     (iss_valid),
        .iss_idx       (iss_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slot chosen per lane by the bench acting as the selectors (-1 = no grant).
    int a_slot [REQS];
    int i_slot [REQS];

    // Reference model: one record per RS entry plus the issue output latches.
    bit m_valid [WIDTH];
    bit m_rdy1  [WIDTH];
    bit m_rdy2  [WIDTH];
    int m_tag1  [WIDTH];
    int m_tag2  [WIDTH];
    bit m_iss_valid [REQS];
    int m_iss_idx   [REQS];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit cdb_match(input int tag);
        for (int j = 0; j < CDB_N; j++)
            if (cdb_valid[j] && int'(cdb_tag[j*TAG_W +: TAG_W]) == tag) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready(input int s);
`ifdef RS_WAKEUP_BYPASS_EN
        return m_valid[s] && (m_rdy1[s] || cdb_match(m_tag1[s])) && (m_rdy2[s] || cdb_match(m_tag2[s]));
`else
        return m_valid[s] && m_rdy1[s] && m_rdy2[s];
`endif
    endfunction

    task automatic clear_inputs();
        reset = 1'b0; squash = 1'b0;
        disp_valid = '0; disp_tag1 = '0; disp_rdy1 = '0; disp_tag2 = '0; disp_rdy2 = '0;
        cdb_valid = '0; cdb_tag = '0; iss_accept = '0;
        for (int k = 0; k < REQS; k++) begin
            a_slot[k] = -1;
            i_slot[k] = -1;
        end
    endtask

    task automatic disp(input int k, input int s, input int t1, input bit r1, input int t2, input bit r2);
        disp_valid[k] = 1'b1;
        a_slot[k] = s;
        disp_tag1[k*TAG_W +: TAG_W] = TAG_W'(t1);
        disp_rdy1[k] = r1;
        disp_tag2[k*TAG_W +: TAG_W] = TAG_W'(t2);
        disp_rdy2[k] = r2;
    endtask

    // Turn chosen slot numbers into the selectors' lane-wise one-hot buses,
    // let inputs settle, and compare every output with the model.
    task automatic settle();
        logic [WIDTH-1:0] e_free, e_ready;
        logic [REQS-1:0]  e_iv;
        int cnt;
        alloc_gnt_bus = '0;
        iss_gnt_bus   = '0;
        for (int k = 0; k < REQS; k++) begin
            if (a_slot[k] >= 0) alloc_gnt_bus[k*WIDTH + a_slot[k]] = 1'b1;
            if (i_slot[k] >= 0) iss_gnt_bus[k*WIDTH + i_slot[k]] = 1'b1;
        end
        #1;
        cnt = 0;
        for (int s = 0; s < WIDTH; s++) begin
            e_free[s]  = !m_valid[s];
            e_ready[s] = m_ready(s);
            if (!m_valid[s]) cnt++;
        end
        for (int k = 0; k < REQS; k++) e_iv[k] = m_iss_valid[k];
        check("free_vec",  32'(free_vec),  32'(e_free));
        check("ready_req", 32'(ready_req), 32'(e_ready));
        check("free_cnt",  32'(free_cnt),  32'(cnt));
        check("rs_full",   32'(rs_full),   32'(cnt < REQS));
        check("iss_valid", 32'(iss_valid), 32'(e_iv));
        for (int k = 0; k < REQS; k++)
            if (m_iss_valid[k]) check($sformatf("iss_idx[%0d]", k), 32'(iss_idx[k*IDX_W +: IDX_W]), 32'(m_iss_idx[k]));
    endtask

    // Apply the entry rules to the model for the current inputs, then clock.
    task automatic advance();
        if (reset) begin
            for (int s = 0; s < WIDTH; s++) begin
                m_valid[s] = 0; m_rdy1[s] = 0; m_rdy2[s] = 0;
            end
            for (int k = 0; k < REQS; k++) begin
                m_iss_valid[k] = 0; m_iss_idx[k] = 0;
            end
        end else if (squash) begin
            for (int s = 0; s < WIDTH; s++) m_valid[s] = 0;
            for (int k = 0; k < REQS; k++) m_iss_valid[k] = 0;
        end else begin
            for (int s = 0; s < WIDTH; s++) begin
                if (m_valid[s] && cdb_match(m_tag1[s])) m_rdy1[s] = 1;
                if (m_valid[s] && cdb_match(m_tag2[s])) m_rdy2[s] = 1;
            end
            for (int k = 0; k < REQS; k++) begin
                if (disp_valid[k] && a_slot[k] >= 0) begin
                    m_valid[a_slot[k]] = 1;
                    m_tag1[a_slot[k]]  = int'(disp_tag1[k*TAG_W +: TAG_W]);
                    m_tag2[a_slot[k]]  = int'(disp_tag2[k*TAG_W +: TAG_W]);
                    m_rdy1[a_slot[k]]  = disp_rdy1[k] || cdb_match(m_tag1[a_slot[k]]);
                    m_rdy2[a_slot[k]]  = disp_rdy2[k] || cdb_match(m_tag2[a_slot[k]]);
                end
            end
            for (int k = 0; k < REQS; k++) begin
                m_iss_valid[k] = (i_slot[k] >= 0) && iss_accept[k];
                if (m_iss_valid[k]) begin
                    m_valid[i_slot[k]] = 0;
                    m_iss_idx[k] = i_slot[k];
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic random_inputs(input int issue_pct);
        int free_q[$];
        int rdy_q[$];
        int p;
        clear_inputs();
        for (int j = 0; j < CDB_N; j++) begin
            cdb_valid[j] = 1'($urandom_range(0, 1));
            cdb_tag[j*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 15));
        end
        for (int s = 0; s < WIDTH; s++) begin
            if (!m_valid[s]) free_q.push_back(s);
            if (m_ready(s)) rdy_q.push_back(s);
        end
        for (int k = 0; k < REQS; k++) begin
            if ($urandom_range(0, 3) != 0 && free_q.size() > 0) begin
                p = int'($urandom_range(0, free_q.size() - 1));
                disp(k, free_q[p], int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                free_q.delete(p);
            end else begin
                disp_valid[k] = ($urandom_range(0, 15) == 0);
            end
            if (int'($urandom_range(0, 99)) < issue_pct && rdy_q.size() > 0) begin
                p = int'($urandom_range(0, rdy_q.size() - 1));
                i_slot[k] = rdy_q[p];
                rdy_q.delete(p);
            end
            iss_accept[k] = ($urandom_range(0, 3) != 0);
        end
        squash = ($urandom_range(0, 39) == 0);
        reset  = ($urandom_range(0, 499) == 0);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        advance();
        advance();

        // Reset then idle.
        clear_inputs();
        settle();
        check("reset free_cnt",  32'(free_cnt),  32'd16);
        check("reset rs_full",   32'(rs_full),   32'd0);
        check("reset ready_req", 32'(ready_req), 32'd0);
        check("reset iss_valid", 32'(iss_valid), 32'd0);
        advance();

        // Three ready dispatches into slots 0/1/2, then issue all of them.
        clear_inputs();
        for (int k = 0; k < REQS; k++) disp(k, k, 1, 1'b1, 2, 1'b1);
        settle();
        advance();
        clear_inputs();
        for (int k = 0; k < REQS; k++) begin
            i_slot[k] = k;
            iss_accept[k] = 1'b1;
        end
        settle();
        check("three ready_req", 32'(ready_req), 32'h0007);
        advance();
        clear_inputs();
        settle();
        check("three iss_valid", 32'(iss_valid), 32'h7);
        check("three iss_idx",   32'(iss_idx),   32'h210);
        check("three free_cnt",  32'(free_cnt),  32'd16);
        advance();

        // Slot 5 waits on tag 9, broadcast two cycles after dispatch.
        clear_inputs();
        disp(0, 5, 9, 1'b0, 0, 1'b1);
        settle();
        advance();
        clear_inputs();
        settle();
        advance();
        clear_inputs();
        cdb_valid[1] = 1'b1;
        cdb_tag[1*TAG_W +: TAG_W] = 6'd9;
        settle();
`ifdef RS_WAKEUP_BYPASS_EN
        check("wake same cycle", 32'(ready_req[5]), 32'd1);
`else
        check("wake same cycle", 32'(ready_req[5]), 32'd0);
`endif
        advance();
        clear_inputs();
        settle();
        check("wake next cycle", 32'(ready_req[5]), 32'd1);
        i_slot[2] = 5;
        iss_accept[2] = 1'b1;
        settle();
        advance();

        // Dispatch-time bypass: both sources tag 12 while CDB broadcasts 12.
        clear_inputs();
        disp(1, 7, 12, 1'b0, 12, 1'b0);
        cdb_valid[2] = 1'b1;
        cdb_tag[2*TAG_W +: TAG_W] = 6'd12;
        settle();
        advance();
        clear_inputs();
        settle();
        check("disp bypass", 32'(ready_req), 32'h0080);
        i_slot[0] = 7;
        iss_accept[0] = 1'b1;
        settle();
        advance();

        // Fill 14 entries; only slot 3 is ready.
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            for (int k = 0; k < REQS; k++)
                if (c*3 + k < 14) disp(k, c*3 + k, 63, (c*3 + k == 3), 63, (c*3 + k == 3));
            settle();
            advance();
        end
        clear_inputs();
        settle();
        check("fill rs_full",  32'(rs_full),  32'd1);
        check("fill free_cnt", 32'(free_cnt), 32'd2);
        i_slot[0] = 3;
        settle();
        advance();
        clear_inputs();
        settle();
        check("noaccept iss_valid", 32'(iss_valid), 32'd0);
        check("noaccept ready_req", 32'(ready_req), 32'h0008);
        check("noaccept free_cnt",  32'(free_cnt),  32'd2);

        // Squash against two dispatches and one accepted issue.
        disp(0, 14, 1, 1'b1, 1, 1'b1);
        disp(1, 15, 1, 1'b1, 1, 1'b1);
        i_slot[2] = 3;
        iss_accept[2] = 1'b1;
        squash = 1'b1;
        settle();
        advance();
        clear_inputs();
        settle();
        check("squash free_cnt",  32'(free_cnt),  32'd16);
        check("squash iss_valid", 32'(iss_valid), 32'd0);
        advance();

        // Randomized traffic; issue pressure alternates so the station both fills and drains.
        for (int i = 0; i < 3000; i++) begin
            random_inputs(((i / 150) % 2 == 0) ? 25 : 85);
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
